// File: rtl/color_arbiter.sv
// -----------------------------------------------------------------------------
// color_arbiter
//
// Per-pixel layer scheduler feeding color_mapper. Picks the highest-priority
// opaque sprite layer (layer 0 wins), looks its index up in a writable
// RGB888 palette (or passes the background colour when no layer is opaque),
// then applies a frame-stepped screen fade. Three-stage pipeline, no stall:
//   stage 1 : priority select       -> idx / sel_bg / bg / valid
//   stage 2 : palette or background -> unfaded colour (0 when not valid)
//   stage 3 : fade scaling          -> color_data / color_valid
//
// Ports
//   Clk          pixel clock
//   Reset        asynchronous, active-high reset
//   pixel_valid  beam is in the active display area
//   frame_start  one-cycle pulse per frame; the only event that steps a fade
//   layer_hit    per-layer coverage of the current pixel
//   layer_idx    per-layer palette index, layer i at [i*IDX_W +: IDX_W]
//   bg_color     background / starfield colour
//   pal_we       palette write enable
//   pal_waddr    palette write address
//   pal_wdata    palette write data (RGB888)
//   fade_req     one-cycle request to start a fade-out (IDLE) or fade-in (BLACK)
//   color_data   faded RGB888 output, 3 cycles after the inputs
//   color_valid  pixel_valid delayed by 3 cycles
//   fade_busy    fade FSM is not IDLE
//   collide      layer 0 overlapped another opaque layer on a valid pixel
//
// Build option
//   COLOR_ARB_COLLIDE_EN : when defined, the collision flag is computed and
//   pipelined alongside color_data; otherwise collide is tied low.
// -----------------------------------------------------------------------------
module color_arbiter #(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        pixel_valid,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [23:0]                 bg_color,
  input  logic                        pal_we,
  input  logic [IDX_W-1:0]            pal_waddr,
  input  logic [23:0]                 pal_wdata,
  input  logic                        fade_req,
  output logic [23:0]                 color_data,
  output logic                        color_valid,
  output logic                        fade_busy,
  output logic                        collide
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_OUT = 2'd1,
    S_BLACK    = 2'd2,
    S_FADE_IN  = 2'd3
  } state_t;

  // (c * level) >> 3 for one 8-bit channel; level 8 is unity gain.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [3:0] lvl);
    logic [11:0] prod;
    prod = {4'b0000, c} * {8'b0000_0000, lvl};
    return 8'(prod >> 3);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: priority select
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] opaque_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic                  win_bg_s;

  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_sel_bg_q;
  logic [23:0]      s1_bg_q;
  logic             s1_valid_q;

  // Index 0 is transparent; scan from the lowest priority upward so the
  // lowest-numbered opaque layer is the one left standing.
  always_comb begin
    opaque_s  = '0;
    win_idx_s = '0;
    win_bg_s  = 1'b1;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      opaque_s[i] = layer_hit[i] && (layer_idx[i*IDX_W +: IDX_W] != '0);
      win_idx_s   = opaque_s[i] ? layer_idx[i*IDX_W +: IDX_W] : win_idx_s;
      win_bg_s    = opaque_s[i] ? 1'b0 : win_bg_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Palette: write lands at the clock edge, so a stage-2 read in the same
  // cycle still sees the previous contents.
  // ---------------------------------------------------------------------------
  logic [23:0] pal_q [DEPTH];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) pal_q[i] <= 24'h000000;
    end else if (pal_we) begin
      pal_q[pal_waddr] <= pal_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 / stage 3 datapath
  // ---------------------------------------------------------------------------
  logic [23:0] s2_color_d, s2_color_q;
  logic        s2_valid_q;
  logic [23:0] color_d, color_q;
  logic        color_valid_q;
  logic [3:0]  level_q, level_d;

  always_comb begin
    if (!s1_valid_q) begin
      s2_color_d = 24'h000000;
    end else if (s1_sel_bg_q) begin
      s2_color_d = s1_bg_q;
    end else begin
      s2_color_d = pal_q[s1_idx_q];
    end
    color_d = {scale_ch(s2_color_q[23:16], level_q),
               scale_ch(s2_color_q[15:8],  level_q),
               scale_ch(s2_color_q[7:0],   level_q)};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_idx_q      <= '0;
      s1_sel_bg_q   <= 1'b0;
      s1_bg_q       <= 24'h000000;
      s1_valid_q    <= 1'b0;
      s2_color_q    <= 24'h000000;
      s2_valid_q    <= 1'b0;
      color_q       <= 24'h000000;
      color_valid_q <= 1'b0;
    end else begin
      s1_idx_q      <= win_idx_s;
      s1_sel_bg_q   <= win_bg_s;
      s1_bg_q       <= bg_color;
      s1_valid_q    <= pixel_valid;
      s2_color_q    <= s2_color_d;
      s2_valid_q    <= s1_valid_q;
      color_q       <= color_d;
      color_valid_q <= s2_valid_q;
    end
  end

  assign color_data  = color_q;
  assign color_valid = color_valid_q;

  // ---------------------------------------------------------------------------
  // Fade FSM (state register / next state / outputs)
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   fade_busy_q, fade_busy_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      level_q     <= 4'd8;
      fade_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      fade_busy_q <= fade_busy_d;
    end
  end

  // A fade_req coinciding with frame_start in IDLE only arms FADE_OUT; the
  // first step waits for the next frame_start.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      S_IDLE: begin
        level_d = 4'd8;
        state_d = fade_req ? S_FADE_OUT : S_IDLE;
      end
      S_FADE_OUT: begin
        if (frame_start) begin
          level_d = level_q - 4'd1;
          state_d = (level_q == 4'd1) ? S_BLACK : S_FADE_OUT;
        end else begin
          state_d = S_FADE_OUT;
        end
      end
      S_BLACK: begin
        level_d = 4'd0;
        state_d = fade_req ? S_FADE_IN : S_BLACK;
      end
      S_FADE_IN: begin
        if (frame_start) begin
          level_d = level_q + 4'd1;
          state_d = (level_q == 4'd7) ? S_IDLE : S_FADE_IN;
        end else begin
          state_d = S_FADE_IN;
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = 4'd8;
      end
    endcase
  end

  // fade_busy is registered from the next state so it tracks state_q exactly.
  always_comb begin
    fade_busy_d = (state_d != S_IDLE);
  end

  assign fade_busy = fade_busy_q;

  // ---------------------------------------------------------------------------
  // Collision flag
  // ---------------------------------------------------------------------------
`ifdef COLOR_ARB_COLLIDE_EN
  logic coll_s;
  logic s1_coll_q, s2_coll_q, collide_q;

  always_comb begin
    coll_s = pixel_valid && opaque_s[0] && (|opaque_s[NUM_LAYERS-1:1]);
  end

  // Delay the flag through the same three stages as the colour.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_coll_q <= 1'b0;
      s2_coll_q <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      s1_coll_q <= coll_s;
      s2_coll_q <= s1_coll_q;
      collide_q <= s2_coll_q;
    end
  end

  assign collide = collide_q;
`else
  assign collide = 1'b0;
`endif

endmodule

// File: doc/color_arbiter.md
Name: color_arbiter

Overview:
- Per-pixel scheduler that decides which layer's color feeds color_mapper's 24-bit color_data input.
- Sprite layers (ship, enemies, bullets, explosions) each present a palette index and a hit flag every pixel. The block picks the highest-priority layer, looks the index up in a writable palette, and applies a frame-stepped screen fade.
- Sits between the sprite/draw logic and color_mapper, clocked at pixel rate.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has highest priority.
- IDX_W, 4, palette index width; palette depth is 2**IDX_W entries.

Ports:
- Clk  input  1  pixel clock.
- Reset  input  1  asynchronous, active-high reset.
- pixel_valid  input  1  high while the VGA beam is in the active display area.
- frame_start  input  1  one-cycle pulse per frame (VSYNC edge).
- layer_hit  input  NUM_LAYERS  layer i covers the current pixel.
- layer_idx  input  NUM_LAYERS*IDX_W  palette index of layer i, packed at bits [i*IDX_W +: IDX_W].
- bg_color  input  24  background/starfield color for the current pixel.
- pal_we  input  1  palette write enable.
- pal_waddr  input  IDX_W  palette write address.
- pal_wdata  input  24  palette write data, RGB888.
- fade_req  input  1  one-cycle request to start a fade-out or fade-in.
- color_data  output  24  RGB888 to color_mapper.
- color_valid  output  1  color_data corresponds to an active pixel.
- fade_busy  output  1  fade FSM is not in IDLE.
- collide  output  1  collision flag (see Optional Feature).

Behaviour:
- Reset (async, immediate): color_data=0, color_valid=0, fade_busy=0, collide=0, all palette entries=0, FSM=IDLE, fade_level=8, all pipeline registers cleared.
- Transparency: a layer is opaque only if layer_hit[i]=1 and layer_idx[i]!=0. Index 0 is always transparent.
- Stage 1 (registered):
  - Winner = lowest-numbered opaque layer.
  - Register the winner's index, a sel_bg flag (set when no layer is opaque), bg_color and pixel_valid.
- Stage 2 (registered):
  - Palette read of the winner index, or bg_color when sel_bg=1.
  - If the stage-1 pixel_valid was 0, the stage-2 color is 0.
- Stage 3 (registered): fade scaling, per channel out = (c * fade_level) >> 3; c is 8-bit, fade_level is 0..8, intermediate is 12 bits. fade_level=8 passes c through unchanged.
- Latency: exactly 3 Clk from inputs to color_data/color_valid; color_valid equals pixel_valid delayed by 3. Pipeline runs every cycle, no stall.
- Palette:
  - Synchronous write, 2**IDX_W x 24 registers.
  - A write and a read of the same address in the same cycle returns the old value; the new value is visible the next cycle.
- Fade FSM, all stepping on frame_start only:
  - IDLE: fade_level=8. fade_req -> FADE_OUT.
  - FADE_OUT: fade_level decrements by 1 per frame_start. When it reaches 0 -> BLACK (same edge).
  - BLACK: fade_level=0. fade_req -> FADE_IN.
  - FADE_IN: fade_level increments by 1 per frame_start. When it reaches 8 -> IDLE.
  - fade_req is ignored in FADE_OUT and FADE_IN.
  - fade_req and frame_start together in IDLE: enter FADE_OUT only; the first decrement happens on the next frame_start.
  - fade_busy = (state != IDLE), registered.
- A fade_level change takes effect on pixels entering stage 3 on the following cycle; no mid-pixel glitch.
- Reset mid-fade: returns to IDLE with fade_level=8.

Optional Feature:
- Macro: COLOR_ARB_COLLIDE_EN.
- Defined:
  - collide is registered and aligned with color_data.
  - It is 1 for a pixel where pixel_valid=1 and layer 0 is opaque together with any other opaque layer.
  - Layers 1..N-1 overlapping without layer 0 do not set it.
- Undefined: collide is tied to 0 and no collision logic is built.

Test Plan:
- Reset with pal_we pulses active -> all outputs 0, palette entries read back 0, fade_busy=0.
- Write pal[3]=0xFF0000. Set layer_hit=4'b0110, layer_idx1=3, layer_idx2=5, pixel_valid=1 -> 3 cycles later color_data=0xFF0000, color_valid=1.
- layer_hit=4'b0001 with layer_idx0=0 (transparent), bg_color=0x123456 -> color_data=0x123456. With pixel_valid=0 -> color_data=0, color_valid=0.
- Write pal[3] and read index 3 in the same cycle -> the old value comes out; the next pixel shows the new value.
- Pixel 0xFF8040, fade_req then 4 frame_start pulses -> fade_level=4, color 0x7F4020. After 8 pulses -> BLACK, 0x000000, fade_busy=1. fade_req plus 8 more pulses -> IDLE, 0xFF8040, fade_busy=0. fade_req during FADE_OUT is ignored.
- With COLOR_ARB_COLLIDE_EN: layer_hit=4'b0101, both indices nonzero -> collide=1 aligned with color_valid. layer_hit=4'b0110 -> collide=0. With the macro undefined -> collide=0 always.
